// File: rtl/mul_ctrl_if.sv
// rtl/mul_ctrl_if.sv - request/response and ALU signal bundle for the shift-and-add multiplier
//
// Purpose: groups the multiply request/response and the ALU drive/capture
// signals so the controller and its environment connect through one port.
//
// Signals:
//   start          request a multiply (honoured only while ready=1)
//   x, y           4-bit multiplicand / multiplier
//   alu_r, alu_c   ALU result and adder carry-out (combinational, same cycle)
//   alu_op         ALU op code: 3'b010 = A+B, 3'b000 = pass A
//   alu_a, alu_b   ALU operands
//   ready          controller idle
//   done           one-cycle pulse when product becomes valid
//   product        8-bit result, held until the next completed operation
//
// Modports:
//   slave   the multiply controller
//   master  the requester plus ALU side

interface mul_ctrl_if;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] alu_r;
    logic       alu_c;
    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       ready;
    logic       done;
    logic [7:0] product;

    modport slave (
        input  start, x, y, alu_r, alu_c,
        output alu_op, alu_a, alu_b, ready, done, product
    );

    modport master (
        output start, x, y, alu_r, alu_c,
        input  alu_op, alu_a, alu_b, ready, done, product
    );
endinterface

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - 4x4 unsigned shift-and-add multiplier sequencer driving an external 4-bit ALU
//
// Purpose: accepts x/y on start, then alternates ADD and SHIFT cycles four
// times using the external ALU as its only adder, and presents the 8-bit
// product with a one-cycle done pulse. Latency 9 cycles from the accepting
// edge; one multiply every 10 cycles.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    mul_ctrl_if.slave (start/x/y in, ALU drive/capture, ready/done/product out)

module mul_ctrl (
    input  logic         clk,
    input  logic         reset,
    mul_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b000;

    state_t     state_q,   state_d;
    logic [3:0] mc_q,      mc_d;
    logic [3:0] hi_q,      hi_d;
    logic [3:0] lo_q,      lo_d;
    logic       cy_q,      cy_d;
    logic [1:0] cnt_q,     cnt_d;
    logic       ready_q,   ready_d;
    logic       done_q,    done_d;
    logic [7:0] product_q, product_d;
    logic [2:0] alu_op_q,  alu_op_d;
    logic [3:0] alu_a_q,   alu_a_d;
    logic [3:0] alu_b_q,   alu_b_d;

    // Value of {hi,lo} after the shift; also feeds the ALU drive for the next ADD.
    logic [3:0] shift_hi;
    logic [3:0] shift_lo;

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cy_d      = cy_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        product_d = product_q;
        alu_op_d  = OP_PASS;
        alu_a_d   = 4'h0;
        alu_b_d   = 4'h0;
        shift_hi  = {cy_q, hi_q[3:1]};
        shift_lo  = {hi_q[0], lo_q[3:1]};

        // ALU outputs are registered, so the drive for an ADD cycle is
        // computed on the edge that enters it, from the values hi/lo/mc
        // will hold during that cycle.
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mc_d     = bus.x;
                    lo_d     = bus.y;
                    hi_d     = 4'h0;
                    cy_d     = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = ST_ADD;
                    alu_op_d = bus.y[0] ? OP_ADD : OP_PASS;
                    alu_a_d  = 4'h0;
                    alu_b_d  = bus.x;
                end else begin
                    ready_d  = 1'b1;
                end
            end
            ST_ADD: begin
                // A pass cycle returns hi with carry 0, so latching is always safe.
                hi_d    = bus.alu_r;
                cy_d    = bus.alu_c;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                hi_d  = shift_hi;
                lo_d  = shift_lo;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    product_d = {shift_hi, shift_lo};
                end else begin
                    state_d  = ST_ADD;
                    alu_op_d = shift_lo[0] ? OP_ADD : OP_PASS;
                    alu_a_d  = shift_hi;
                    alu_b_d  = mc_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mc_q      <= 4'h0;
            hi_q      <= 4'h0;
            lo_q      <= 4'h0;
            cy_q      <= 1'b0;
            cnt_q     <= 2'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= 8'h00;
            alu_op_q  <= OP_PASS;
            alu_a_q   <= 4'h0;
            alu_b_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cy_q      <= cy_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            product_q <= product_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.alu_op  = alu_op_q;
    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl with a behavioural ALU and product model

module tb_mul_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   last_done_cyc;

    mul_ctrl_if bus ();

    mul_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 010 adds with carry-out, 000 passes A.
    always_comb begin
        bus.alu_r = 4'h0;
        bus.alu_c = 1'b0;
        case (bus.alu_op)
            3'b010:  {bus.alu_c, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b000:  bus.alu_r = bus.alu_a;
            default: bus.alu_r = 4'h0;
        endcase
    end

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [7:0]  prod;
        logic [11:0] ops;   // {op4, op3, op2, op1}
        logic        cy;
    } vec_t;

    vec_t vecs [6];

    logic [7:0]  r_prod;
    int          r_lat;
    logic [11:0] r_ops;
    logic        r_cy;
    int          r_dcnt;
    bit          r_rdy_ok;
    bit          r_hold_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 10
    // (counted from the accepting edge), so consecutive calls are back-to-back.
    task automatic run_mul(input logic [3:0] xa, input logic [3:0] ya, input int inj1, input int inj2);
        logic [7:0] prev;
        prev      = bus.product;
        bus.start = 1'b1;
        bus.x     = xa;
        bus.y     = ya;
        r_lat = 0; r_dcnt = 0; r_ops = '0; r_cy = 1'b0;
        r_rdy_ok = 1'b1; r_hold_ok = 1'b1; r_prod = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k % 2 == 1 && k <= 7) begin
                r_ops[((k - 1) / 2) * 3 +: 3] = bus.alu_op;
                r_cy = r_cy | bus.alu_c;
            end
            if (bus.done === 1'b1) begin
                r_dcnt++;
                if (r_lat == 0) r_lat = k;
                last_done_cyc = cyc;
            end
            if (k <= 9 && bus.ready !== 1'b0) r_rdy_ok = 1'b0;
            if (k == 10 && bus.ready !== 1'b1) r_rdy_ok = 1'b0;
            if (k <= 8 && bus.product !== prev) r_hold_ok = 1'b0;
            if (k == 9) r_prod = bus.product;
            if (k == 10 && bus.product !== r_prod) r_hold_ok = 1'b0;
            if (k == inj1 || k == inj2) begin
                bus.start = 1'b1;
                bus.x     = 4'd2;
                bus.y     = 4'd2;
            end else begin
                bus.start = 1'b0;
                bus.x     = 4'($urandom);
                bus.y     = 4'($urandom);
            end
        end
    endtask

    // Expected ADD-cycle op codes follow the multiplier bits, LSB first.
    function automatic logic [11:0] model_ops(input logic [3:0] yv);
        logic [11:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) o[i * 3 +: 3] = yv[i] ? 3'b010 : 3'b000;
        return o;
    endfunction

    task automatic check_run(input string tag, input logic [7:0] exp_prod, input logic [11:0] exp_ops);
        check({tag, ".product"}, r_prod, exp_prod);
        check({tag, ".latency"}, r_lat, 9);
        check({tag, ".done_cnt"}, r_dcnt, 1);
        check({tag, ".alu_ops"}, r_ops, exp_ops);
        check({tag, ".ready"}, r_rdy_ok, 1);
        check({tag, ".hold"}, r_hold_ok, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          no_done;
        int          base;
        int          prev_done;
        logic [7:0]  p;
        logic [3:0]  xa;
        logic [3:0]  ya;

        checks = 0; errors = 0; cyc = 0; last_done_cyc = 0;
        reset = 1'b1; bus.start = 1'b0; bus.x = 4'h0; bus.y = 4'h0;

        vecs[0] = '{4'd5,  4'd3,  8'h0F, 12'b000_000_010_010, 1'b0};
        vecs[1] = '{4'd15, 4'd15, 8'hE1, 12'b010_010_010_010, 1'b1};
        vecs[2] = '{4'd9,  4'd0,  8'h00, 12'b000_000_000_000, 1'b0};
        vecs[3] = '{4'd0,  4'd15, 8'h00, 12'b010_010_010_010, 1'b0};
        vecs[4] = '{4'd1,  4'd1,  8'h01, 12'b000_000_000_010, 1'b0};
        vecs[5] = '{4'd8,  4'd9,  8'h48, 12'b010_000_000_010, 1'b0};

        #1;
        check("rst.ready",   bus.ready,   1);
        check("rst.done",    bus.done,    0);
        check("rst.product", bus.product, 8'h00);
        check("rst.alu_op",  bus.alu_op,  3'b000);
        check("rst.alu_a",   bus.alu_a,   4'h0);
        check("rst.alu_b",   bus.alu_b,   4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].x, vecs[i].y, 0, 0);
            check_run($sformatf("vec%0d", i), vecs[i].prod, vecs[i].ops);
            check($sformatf("vec%0d.carry", i), r_cy, vecs[i].cy);
        end

        // Starts during busy cycles 3 and 9 must be ignored
        run_mul(4'd7, 4'd6, 3, 9);
        check_run("ignore", 8'h2A, 12'b000_010_010_000);
        no_done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.ready !== 1'b1) no_done = 1'b0;
        end
        check("ignore.no_extra_op", no_done, 1);

        // Reset in the middle of an operation
        bus.start = 1'b1; bus.x = 4'd12; bus.y = 4'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid.alu_b", bus.alu_b, 4'd12);
        check("mid.ready", bus.ready, 0);
        #1 reset = 1'b1;
        #1;
        check("arst.ready",   bus.ready,   1);
        check("arst.done",    bus.done,    0);
        check("arst.product", bus.product, 8'h00);
        check("arst.alu_op",  bus.alu_op,  3'b000);
        check("arst.alu_b",   bus.alu_b,   4'h0);
        no_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        reset = 1'b0;
        check("arst.no_done", no_done, 1);
        run_mul(4'd3, 4'd4, 0, 0);
        check_run("post_rst", 8'h0C, model_ops(4'd4));

        // All 256 pairs, back-to-back, in a randomly rotated order
        base = $urandom_range(0, 255);
        for (int i = 0; i < 256; i++) begin
            p  = 8'(i) ^ 8'(base);
            xa = p[7:4];
            ya = p[3:0];
            prev_done = last_done_cyc;
            run_mul(xa, ya, 0, 0);
            check_run($sformatf("pair_%0d_%0d", xa, ya), 8'(int'(xa) * int'(ya)), model_ops(ya));
            if (i > 0) check($sformatf("pair_%0d_%0d.spacing", xa, ya), last_done_cyc - prev_done, 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
